// File: rtl/shift_and_subtract_binary_divider.sv
// Sequential restoring divider: one quotient bit per clock via shift/compare/subtract,
// framed by a start/done handshake with an explicit divide-by-zero flag.
module shift_and_subtract_binary_divider #(
    parameter int unsigned m = 8,
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] A,
    input  logic [n-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [m-1:0] Q,
    output logic [n-1:0] R,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(m + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [m-1:0]  dvd;
    logic [n-1:0]  dvs;
    logic [n-1:0]  p;
    logic [CW-1:0] cnt;

    logic [n:0]    p_sh;
    logic          ge;
    logic [n-1:0]  p_nx;
    logic [m-1:0]  dvd_nx;

    // One restoring step; quotient bits shift into the dividend register as it empties.
    always_comb begin
        p_sh   = {p, dvd[m-1]};
        ge     = (p_sh >= {1'b0, dvs});
        p_nx   = ge ? n'(p_sh - {1'b0, dvs}) : p_sh[n-1:0];
        dvd_nx = {dvd[m-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            p           <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd <= A;
                        dvs <= B;
                        p   <= '0;
                        cnt <= CW'(m);
                        if (B == '0) begin
                            Q           <= '1;
                            R           <= n'(A);
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd <= dvd_nx;
                    p   <= p_nx;
                    cnt <= cnt - CW'(1);
                    // Last step: publish the result straight from the step logic.
                    if (cnt == CW'(1)) begin
                        Q           <= dvd_nx;
                        R           <= p_nx;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_and_subtract_binary_divider.sv
// Self-checking bench for shift_and_subtract_binary_divider against an arithmetic reference.
module tb_shift_and_subtract_binary_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       busy;
    logic       done;
    logic [7:0] q_out;
    logic [7:0] r_out;
    logic       dz_out;

    int n_checks = 0;
    int n_pass   = 0;

    shift_and_subtract_binary_divider #(.m(8), .n(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
        .busy(busy), .done(done), .Q(q_out), .R(r_out), .div_by_zero(dz_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; divide-by-zero gives all-ones and the dividend.
    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? 8'hFF : 8'(a / b);
    endfunction
    function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? a : 8'(a % b);
    endfunction

    // Issue one operation and wait (bounded) for done; returns what was observed.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r, output logic dz,
                         output int lat, output int busy_n, output logic ok);
        q = '0; r = '0; dz = 1'b0; lat = -1; busy_n = 0; ok = 1'b0;
        @(negedge clk); a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); start = 1'b0;
            if (done) begin
                lat = i; q = q_out; r = r_out; dz = dz_out; ok = 1'b1;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if ({busy, done, dz_out} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, dz_out}); else n_pass++;
        n_checks++; if (q_out !== 8'd0) $display("FAIL reset_q: got %0d want 0", q_out); else n_pass++;
        n_checks++; if (r_out !== 8'd0) $display("FAIL reset_r: got %0d want 0", r_out); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [7:0] a, input logic [7:0] b, input string nm);
        logic [7:0] q, r; logic dz, ok; int lat, bn;
        do_op(a, b, q, r, dz, lat, bn, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL %s_timeout: got no done want done", nm); else n_pass++;
        n_checks++; if (q !== ref_q(a, b)) $display("FAIL %s_q: got %0d want %0d", nm, q, ref_q(a, b)); else n_pass++;
        n_checks++; if (r !== ref_r(a, b)) $display("FAIL %s_r: got %0d want %0d", nm, r, ref_r(a, b)); else n_pass++;
        n_checks++; if (dz !== 1'b0) $display("FAIL %s_dz: got %b want 0", nm, dz); else n_pass++;
        n_checks++; if (lat !== 8) $display("FAIL %s_latency: got %0d want 8", nm, lat); else n_pass++;
        n_checks++; if (bn !== 8) $display("FAIL %s_busy_cycles: got %0d want 8", nm, bn); else n_pass++;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", nm, done); else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r; logic dz, ok; int lat, bn;
        do_op(8'd5, 8'd0, q, r, dz, lat, bn, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL dz_timeout: got no done want done"); else n_pass++;
        n_checks++; if (q !== 8'd255) $display("FAIL dz_q: got %0d want 255", q); else n_pass++;
        n_checks++; if (r !== 8'd5) $display("FAIL dz_r: got %0d want 5", r); else n_pass++;
        n_checks++; if (dz !== 1'b1) $display("FAIL dz_flag: got %b want 1", dz); else n_pass++;
        n_checks++; if (lat !== 0) $display("FAIL dz_latency: got %0d want 0", lat); else n_pass++;
        n_checks++; if (bn !== 0) $display("FAIL dz_busy: got %0d want 0", bn); else n_pass++;
        @(negedge clk);
        n_checks++; if (dz_out !== 1'b1) $display("FAIL dz_held: got %b want 1", dz_out); else n_pass++;
        test_basic(8'd9, 8'd3, "after_dz");
    endtask

    task automatic test_ignore_start();
        int n_done = 0; int at = -1; logic [7:0] q = '0, r = '0;
        @(negedge clk); a_in = 8'd200; b_in = 8'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a_in = 8'd1; b_in = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 4; i < 24; i++) begin
            @(negedge clk);
            if (done) begin n_done++; if (at < 0) begin at = i; q = q_out; r = r_out; end end
        end
        n_checks++; if (n_done !== 1) $display("FAIL ign_done_count: got %0d want 1", n_done); else n_pass++;
        n_checks++; if (at !== 8) $display("FAIL ign_latency: got %0d want 8", at); else n_pass++;
        n_checks++; if (q !== 8'd15) $display("FAIL ign_q: got %0d want 15", q); else n_pass++;
        n_checks++; if (r !== 8'd5) $display("FAIL ign_r: got %0d want 5", r); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        @(negedge clk); a_in = 8'd100; b_in = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({busy, done, dz_out} !== 3'b000) $display("FAIL mid_flags: got %b want 000", {busy, done, dz_out}); else n_pass++;
        n_checks++; if ({q_out, r_out} !== 16'd0) $display("FAIL mid_qr: got %0d/%0d want 0/0", q_out, r_out); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_checks++; if (n_done !== 0) $display("FAIL mid_no_done: got %0d want 0", n_done); else n_pass++;
        test_basic(8'd200, 8'd13, "after_rst");
    endtask

    task automatic test_back_to_back();
        int last = -1; int n_done = 0; int bad_gap = 0; int bad_val = 0;
        @(negedge clk); a_in = 8'd100; b_in = 8'd7; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (last >= 0 && (i - last) != 10) bad_gap++;
                if (q_out !== 8'd14 || r_out !== 8'd2) bad_val++;
                last = i;
            end
        end
        start = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++; if (n_done !== 4) $display("FAIL b2b_count: got %0d want 4", n_done); else n_pass++;
        n_checks++; if (bad_gap !== 0) $display("FAIL b2b_interval: got %0d bad gaps want 0", bad_gap); else n_pass++;
        n_checks++; if (bad_val !== 0) $display("FAIL b2b_values: got %0d bad results want 0", bad_val); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] a, b, q, r; logic dz, ok; int lat, bn;
        for (int k = 0; k < 120; k++) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 1));
            do_op(a, b, q, r, dz, lat, bn, ok);
            n_checks++;
            if (ok !== 1'b1 || q !== ref_q(a, b) || r !== ref_r(a, b) || dz !== 1'b0)
                $display("FAIL rand_%0d: %0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                         k, a, b, q, r, dz, ref_q(a, b), ref_r(a, b));
            else n_pass++;
            n_checks++;
            if ((32'(q) * 32'(b) + 32'(r)) !== 32'(a) || r >= b)
                $display("FAIL rand_identity_%0d: %0d/%0d got q=%0d r=%0d", k, a, b, q, r);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'd100, 8'd7, "basic");
        test_basic(8'd255, 8'd1, "by_one");
        test_basic(8'd3, 8'd200, "small");
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_and_subtract_binary_divider.md
# shift_and_subtract_binary_divider

Sequential restoring divider that inverts the datapath's shift-and-add multiplier: it takes an m-bit unsigned dividend and an n-bit unsigned divisor and produces quotient and remainder. It resolves one quotient bit per clock using a shift/compare/subtract step. A start/done handshake frames each operation, and divide-by-zero is flagged explicitly. It sits alongside the multiplier in the arithmetic datapath and shares its clock and reset.

## Interface
- m, 8, dividend and quotient width (bits)
- n, 8, divisor and remainder width (bits)

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- A  input  m  dividend, unsigned; captured on the accepting edge
- B  input  n  divisor, unsigned; captured on the accepting edge
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when Q/R/div_by_zero are valid
- Q  output  m  quotient, registered
- R  output  n  remainder, registered
- div_by_zero  output  1  high with done when captured B was 0; held with Q/R

## Operation
- States:
  - IDLE, CALC, DONE.
  - IDLE→CALC on start=1 with B≠0.
  - IDLE→DONE on start=1 with B=0.
  - CALC→DONE when the bit counter reaches 0 after m steps.
  - DONE→IDLE unconditionally after one cycle.
- Capture on acceptance:
  - dividend shift register ← A; divisor register ← B.
  - partial remainder P (n+1 bits) ← 0; counter ← m.
- CALC step, one per cycle:
  - P' = {P[n-1:0], dividend MSB}, then shift the dividend left by 1.
  - If P' ≥ {1'b0, divisor}: P ← P' − divisor and shift quotient bit 1 in at the LSB.
  - Otherwise: P ← P' and shift quotient bit 0 in.
  - All compares and subtracts are n+1 bits wide. P never exceeds divisor−1 after a step, so the final remainder fits in n bits.
- Completion at the final CALC edge:
  - Q ← quotient register; R ← P[n-1:0]; div_by_zero ← 0.
- Divide by zero on the accepting edge:
  - Q ← all ones; R ← A[n-1:0] (zero-extended if n>m); div_by_zero ← 1.
- Q, R and div_by_zero hold their values until the next completion or reset.
- start is ignored in CALC and DONE. A and B changing after capture has no effect.
- Quotient and remainder satisfy A = Q·B + R with R < B for every B ≠ 0.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, Q=0, R=0, div_by_zero=0, internal registers 0.
- Accepting edge t0 (IDLE, start=1, B≠0):
  - busy=1 from t0 to t0+m.
  - At edge t0+m, results load; done=1 and busy=0 for the cycle t0+m..t0+m+1.
  - Latency is m cycles, start edge to done.
- Divide by zero: done=1 for the cycle t0..t0+1; busy stays 0. Latency is 1 cycle.
- Back-to-back: start held high is accepted at the first IDLE edge after DONE. Minimum issue interval is m+2 cycles (m=8: 10).
- Reset mid-operation: the operation is aborted. Outputs return to reset values immediately, no done pulse is produced, and the next start is accepted normally after rst deasserts.
- start=1 in the DONE cycle is not accepted. It must still be high at the following IDLE edge to be taken.

## Test plan
- A=100, B=7, start pulse → busy 8 cycles; done pulse at t0+8 with Q=14, R=2, div_by_zero=0.
- A=255, B=1 → Q=255, R=0 after 8 cycles. Then A=3, B=200 → Q=0, R=3.
- A=5, B=0 → done one cycle after start with Q=255, R=5, div_by_zero=1, busy never high. A following 9/3 → Q=3, R=0, div_by_zero=0.
- Start 200/13, change A/B and pulse start at cycle 3 → the second start is ignored. Result is Q=15, R=5 at t0+8, and only one done pulse occurs.
- Start 100/7, assert rst at cycle 4 → Q=R=0, busy=done=0 immediately. Release rst and start 200/13 → Q=15, R=5 at 8 cycles.
- start held high continuously with 100/7 → done pulses every 10 cycles. Random sweep of all A, B with B≠0 → Q·B+R=A and R<B each time.
